// File: rtl/reg_bank_pkg.sv
// Shared types and default parameter values for the multi-read-port register bank.
package reg_bank_pkg;

  localparam int DEF_DATA_W   = 16;
  localparam int DEF_ADDR_W   = 3;
  localparam int DEF_N_READ   = 2;
  localparam int DEF_ZERO_REG = 1;
  localparam int DEF_BYPASS   = 1;

  typedef enum logic [1:0] {
    CLR_IDLE  = 2'd0,
    CLR_CLEAR = 2'd1,
    CLR_DONE  = 2'd2
  } clr_state_t;

endpackage

// File: rtl/reg_bank_clear_fsm.sv
// Sequential bank-clear engine: walks every index once, one entry per cycle,
// then pulses done.
//
// state     | meaning
// ----------+---------------------------------------------------------
// CLR_IDLE  | waiting for clr_req_i
// CLR_CLEAR | busy; zeroing entry clr_idx_o this cycle, then advancing
// CLR_DONE  | one-cycle completion pulse, back to idle
module reg_bank_clear_fsm
  import reg_bank_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_req_i,
  output logic              clr_busy_o,
  output logic              clr_done_o,
  output logic [ADDR_W-1:0] clr_idx_o,
  output logic              clr_we_o
);

  localparam logic [ADDR_W-1:0] LAST_IDX = {ADDR_W{1'b1}};

  clr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= CLR_IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    clr_busy_o = 1'b0;
    clr_done_o = 1'b0;
    clr_we_o   = 1'b0;
    case (state_q)
      CLR_IDLE: begin
        if (clr_req_i) begin
          state_d = CLR_CLEAR;
          idx_d   = '0;
        end
      end
      CLR_CLEAR: begin
        clr_busy_o = 1'b1;
        clr_we_o   = 1'b1;
        idx_d      = idx_q + {{(ADDR_W-1){1'b0}}, 1'b1};
        if (idx_q == LAST_IDX) state_d = CLR_DONE;
      end
      CLR_DONE: begin
        clr_done_o = 1'b1;
        state_d    = CLR_IDLE;
      end
      default: state_d = CLR_IDLE;
    endcase
  end

  assign clr_idx_o = idx_q;

endmodule

// File: rtl/reg_bank_mp.sv
// Multi-read-port register bank with pending bits, optional hardwired-zero
// entry 0, write-to-read bypass and a sequential clear engine.
module reg_bank_mp
  import reg_bank_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int N_READ   = DEF_N_READ,
  parameter int ZERO_REG = DEF_ZERO_REG,
  parameter int BYPASS   = DEF_BYPASS
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [ADDR_W-1:0]        wr_sel_i,
  input  logic [DATA_W-1:0]        wr_data_i,
  input  logic                     rsv_en_i,
  input  logic [ADDR_W-1:0]        rsv_sel_i,
  input  logic [N_READ*ADDR_W-1:0] rd_sel_i,
  output logic [N_READ*DATA_W-1:0] rd_data_o,
  output logic [N_READ-1:0]        rd_pend_o,
  input  logic                     clr_req_i,
  output logic                     clr_busy_o,
  output logic                     clr_done_o,
  output logic                     wr_drop_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;
  logic              wr_drop_q, wr_drop_d;

  logic              clr_busy;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_idx;
  logic              wr_ok, rsv_ok;
  logic              wr_zero, rsv_zero;

  reg_bank_clear_fsm #(.ADDR_W(ADDR_W)) u_clear_fsm (
    .clk        (clk),
    .rst        (rst),
    .clr_req_i  (clr_req_i),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done_o),
    .clr_idx_o  (clr_idx),
    .clr_we_o   (clr_we)
  );

  assign wr_zero  = (ZERO_REG != 0) && (wr_sel_i == '0);
  assign rsv_zero = (ZERO_REG != 0) && (rsv_sel_i == '0);
  assign wr_ok    = wr_en_i && !clr_busy && !wr_zero;
  assign rsv_ok   = rsv_en_i && !clr_busy && !rsv_zero;

  // Reserve is applied after the write so it wins on a same-index collision.
  always_comb begin
    mem_d  = mem_q;
    pend_d = pend_q;
    if (clr_we) begin
      mem_d[clr_idx]  = '0;
      pend_d[clr_idx] = 1'b0;
    end else begin
      if (wr_ok) begin
        mem_d[wr_sel_i]  = wr_data_i;
        pend_d[wr_sel_i] = 1'b0;
      end
      if (rsv_ok) pend_d[rsv_sel_i] = 1'b1;
    end
  end

  assign wr_drop_d = clr_busy && (wr_en_i || rsv_en_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      pend_q    <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      pend_q    <= pend_d;
      wr_drop_q <= wr_drop_d;
    end
  end

  for (genvar k = 0; k < N_READ; k++) begin : g_rd
    logic [ADDR_W-1:0] sel;
    logic              hit;
    logic              is_zero;

    assign sel     = rd_sel_i[k*ADDR_W +: ADDR_W];
    assign is_zero = (ZERO_REG != 0) && (sel == '0);
    assign hit     = (BYPASS != 0) && wr_ok && (wr_sel_i == sel);

    assign rd_data_o[k*DATA_W +: DATA_W] = hit     ? wr_data_i :
                                           is_zero ? '0        : mem_q[sel];
    assign rd_pend_o[k] = hit ? 1'b0 : (is_zero ? 1'b0 : pend_q[sel]);
  end

  assign clr_busy_o = clr_busy;
  assign wr_drop_o  = wr_drop_q;

endmodule

// File: tb/tb_reg_bank_mp.sv
// Scoreboard bench for reg_bank_mp: expected {busy,done,drop,pend,data} words are
// queued as stimulus is driven and popped when the outputs are sampled.
module tb_reg_bank_mp;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en;
  logic [2:0]  wr_sel;
  logic [15:0] wr_data;
  logic        rsv_en;
  logic [2:0]  rsv_sel;
  logic [5:0]  rd_sel;
  logic [31:0] rd_data;
  logic [1:0]  rd_pend;
  logic        clr_req;
  logic        clr_busy;
  logic        clr_done;
  logic        wr_drop;

  int total = 0;
  int bad   = 0;

  logic [36:0] exp_q[$];
  logic [36:0] exp_v;
  logic [36:0] obs_v;

  always #5 clk = ~clk;

  reg_bank_mp dut (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_sel_i   (wr_sel),
    .wr_data_i  (wr_data),
    .rsv_en_i   (rsv_en),
    .rsv_sel_i  (rsv_sel),
    .rd_sel_i   (rd_sel),
    .rd_data_o  (rd_data),
    .rd_pend_o  (rd_pend),
    .clr_req_i  (clr_req),
    .clr_busy_o (clr_busy),
    .clr_done_o (clr_done),
    .wr_drop_o  (wr_drop)
  );

  // Layout: {busy, done, drop, pend[1:0], data_p1, data_p0}
  function automatic logic [36:0] mk(input logic b, input logic d, input logic dr,
                                     input logic [1:0] p, input logic [15:0] d1,
                                     input logic [15:0] d0);
    return {b, d, dr, p, d1, d0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_en = 1'b0; wr_sel = 3'd0; wr_data = 16'h0;
    rsv_en = 1'b0; rsv_sel = 3'd0; clr_req = 1'b0;
  endtask

  task automatic fill_bank();
    for (int i = 1; i < 8; i++) begin
      wr_en = 1'b1; wr_sel = 3'(i); wr_data = 16'(i * 16'h1111);
      tick();
    end
    idle_inputs();
  endtask

  task automatic test_reset();
    idle_inputs();
    rd_sel = 6'd0;
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    tick();
    for (int i = 0; i < 8; i++) begin
      rd_sel = {3'(i), 3'(i)};
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000));
      #1;
      obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
      exp_v = exp_q.pop_front();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL reset_idx%0d got=%h want=%h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_write_read();
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'hBEEF;
    tick();
    idle_inputs();
    rd_sel = {3'd5, 3'd3};
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'hBEEF));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL write_read got=%h want=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_bypass();
    // Reserve r3 first so the bypass must also force the pending bit low.
    rsv_en = 1'b1; rsv_sel = 3'd3;
    tick();
    idle_inputs();
    wr_en = 1'b1; wr_sel = 3'd3; wr_data = 16'h1234;
    rd_sel = {3'd3, 3'd5};
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h0000));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL bypass_same_cycle got=%h want=%h", obs_v, exp_v);
    end
    tick();
    idle_inputs();
    rd_sel = {3'd3, 3'd3};
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h1234));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL bypass_committed got=%h want=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_zero_reg();
    wr_en = 1'b1; wr_sel = 3'd0; wr_data = 16'hFFFF;
    rsv_en = 1'b1; rsv_sel = 3'd0;
    rd_sel = {3'd0, 3'd0};
    for (int step = 0; step < 2; step++) begin
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000));
      #1;
      obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
      exp_v = exp_q.pop_front();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL zero_reg_step%0d got=%h want=%h", step, obs_v, exp_v);
      end
      tick();
      idle_inputs();
    end
  endtask

  task automatic test_pending();
    // Reserve is not forwarded in its own cycle.
    rsv_en = 1'b1; rsv_sel = 3'd2;
    rd_sel = {3'd3, 3'd2};
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h0000));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL rsv_same_cycle got=%h want=%h", obs_v, exp_v);
    end
    tick();
    idle_inputs();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b01, 16'h1234, 16'h0000));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL rsv_pending got=%h want=%h", obs_v, exp_v);
    end
    wr_en = 1'b1; wr_sel = 3'd2; wr_data = 16'h00AA;
    tick();
    idle_inputs();
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h1234, 16'h00AA));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL write_retires got=%h want=%h", obs_v, exp_v);
    end
    wr_en = 1'b1; wr_sel = 3'd4; wr_data = 16'h5555;
    rsv_en = 1'b1; rsv_sel = 3'd4;
    tick();
    idle_inputs();
    rd_sel = {3'd4, 3'd4};
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b11, 16'h5555, 16'h5555));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL rsv_wins_same_idx got=%h want=%h", obs_v, exp_v);
    end
  endtask

  task automatic test_clear();
    logic [15:0] r6v;
    fill_bank();
    rd_sel = {3'd1, 3'd6};
    // Cycle c=0 is the cycle whose closing edge samples clr_req.
    for (int c = 0; c <= 10; c++) begin
      idle_inputs();
      if (c == 0) clr_req = 1'b1;
      if (c == 5) clr_req = 1'b1;
      if (c == 2) begin wr_en = 1'b1; wr_sel = 3'd6; wr_data = 16'hABCD; end
      r6v = (c <= 7) ? 16'h6666 : 16'h0000;
      exp_q.push_back(mk((c >= 1) && (c <= 8), c == 9, c == 3, 2'b00,
                         (c <= 2) ? 16'h1111 : 16'h0000, r6v));
      #1;
      obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
      exp_v = exp_q.pop_front();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL clear_cycle%0d got=%h want=%h", c, obs_v, exp_v);
      end
      tick();
    end
    idle_inputs();
    for (int i = 0; i < 8; i += 2) begin
      rd_sel = {3'(i + 1), 3'(i)};
      exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000));
      #1;
      obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
      exp_v = exp_q.pop_front();
      total++;
      if (obs_v !== exp_v) begin
        bad++;
        $display("FAIL after_clear_idx%0d got=%h want=%h", i, obs_v, exp_v);
      end
    end
  endtask

  task automatic test_clear_reset();
    int done_seen;
    fill_bank();
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    tick(); tick(); tick();
    // Now in cycle t+4 with the clear still running.
    #1;
    rst = 1'b1;
    rd_sel = {3'd7, 3'd6};
    exp_q.push_back(mk(1'b0, 1'b0, 1'b0, 2'b00, 16'h0000, 16'h0000));
    #1;
    obs_v = {clr_busy, clr_done, wr_drop, rd_pend, rd_data};
    exp_v = exp_q.pop_front();
    total++;
    if (obs_v !== exp_v) begin
      bad++;
      $display("FAIL reset_mid_clear got=%h want=%h", obs_v, exp_v);
    end
    tick();
    rst = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 12; c++) begin
      if (clr_done || clr_busy) done_seen++;
      tick();
    end
    total++;
    if (done_seen !== 0) begin
      bad++;
      $display("FAIL no_done_after_reset got=%0d want=0", done_seen);
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    rd_sel = 6'd0;
    test_reset();
    test_write_read();
    test_bypass();
    test_zero_reg();
    test_pending();
    test_clear();
    test_clear_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
